note_recorder: RTL and testbench

- Captures live keyboard presses as a song: each entry is a 4-bit note code plus a hold duration in clock ticks.
- Entry format is the same {note, duration} pair the song library supplies to learning mode, so recordings can be replayed or taught back.
- Sits between the key scanner (pressed_key/key_pressed) and playback/learning logic, which reads entries through an asynchronous read port.

---
 rtl/note_recorder_if.sv | 29 ++
 rtl/note_recorder.sv | 165 ++++++++++++++++
 tb/tb_note_recorder.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/note_recorder_if.sv
// note_recorder_if: control, key-scanner and read-port signals of the note recorder.
// Ports: slave = recorder side (takes control/key/rd_index, drives read data and status);
//        master = controller/playback side (mirror image).
interface note_recorder_if #(
  parameter int DEPTH_LOG2 = 5,
  parameter int DUR_W      = 26
);
  logic                  rec_start;
  logic                  rec_stop;
  logic [3:0]            pressed_key;
  logic                  key_pressed;
  logic [DEPTH_LOG2-1:0] rd_index;
  logic [3:0]            rd_note;
  logic [DUR_W-1:0]      rd_duration;
  logic [DEPTH_LOG2:0]   note_count;
  logic                  recording;
  logic                  full;
  logic                  rec_done;

  modport slave (
    input  rec_start, rec_stop, pressed_key, key_pressed, rd_index,
    output rd_note, rd_duration, note_count, recording, full, rec_done
  );

  modport master (
    output rec_start, rec_stop, pressed_key, key_pressed, rd_index,
    input  rd_note, rd_duration, note_count, recording, full, rec_done
  );
endinterface

// File: rtl/note_recorder.sv
// note_recorder: records live key presses as {note, duration-in-ticks} entries into a
//   2**DEPTH_LOG2 entry buffer; writes are registered, reads (rd_index) are combinational.
// Ports: clk, rst (async, active-high); io (note_recorder_if.slave): rec_start/rec_stop pulses,
//   pressed_key/key_pressed, rd_index -> rd_note/rd_duration, note_count/recording/full/rec_done.
// Optional feature macro RECORD_REST_EN: silences between notes are stored as note 0.
module note_recorder #(
  parameter int DEPTH_LOG2 = 5,
  parameter int DUR_W      = 26,
  parameter int MIN_TICKS  = 1000000
) (
  input  logic           clk,
  input  logic           rst,
  note_recorder_if.slave io
);
  localparam int                  ENTRIES  = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DUR_W-1:0]    MIN_T    = DUR_W'(MIN_TICKS);
  localparam logic [DUR_W-1:0]    DUR_MAX  = '1;

  typedef enum logic [1:0] {IDLE, WAIT_KEY, HOLD} state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_cur_note, w_cur_note_nxt;
  logic [DUR_W-1:0]    r_dur_cnt, w_dur_nxt, w_dur_inc;
  logic [DEPTH_LOG2:0] r_count, w_count_nxt;
  logic                r_full, w_full_nxt;
  logic                r_rec_done, w_done_nxt;
  logic                w_we;
  logic [3:0]          w_wr_note;
  logic [DUR_W-1:0]    w_wr_dur;
  logic                w_active, w_commit_ok, w_rd_hit;
  logic [DUR_W+3:0]    w_rd_ent;
  logic [DUR_W+3:0]    r_mem [ENTRIES];
`ifdef RECORD_REST_EN
  logic [DUR_W-1:0]    r_rest_cnt, w_rest_nxt, w_rest_inc;
`endif

  assign w_active    = io.key_pressed && (io.pressed_key != 4'd0);
  assign w_commit_ok = (r_dur_cnt >= MIN_T);
  assign w_dur_inc   = (r_dur_cnt == DUR_MAX) ? r_dur_cnt : r_dur_cnt + 1'b1;
`ifdef RECORD_REST_EN
  assign w_rest_inc  = (r_rest_cnt == DUR_MAX) ? r_rest_cnt : r_rest_cnt + 1'b1;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_cur_note_nxt = r_cur_note;
    w_dur_nxt      = r_dur_cnt;
    w_count_nxt    = r_count;
    w_full_nxt     = r_full;
    w_done_nxt     = 1'b0;
    w_we           = 1'b0;
    w_wr_note      = r_cur_note;
    w_wr_dur       = r_dur_cnt;
`ifdef RECORD_REST_EN
    w_rest_nxt     = r_rest_cnt;
`endif
    if (io.rec_start) begin
      // Start (or restart) wins over everything, including a same-cycle rec_stop.
      w_count_nxt = '0;
      w_full_nxt  = 1'b0;
      w_dur_nxt   = '0;
      w_state_nxt = WAIT_KEY;
`ifdef RECORD_REST_EN
      w_rest_nxt  = '0;
`endif
    end else begin
      case (r_state)
        IDLE: ;
        WAIT_KEY: begin
          if (io.rec_stop) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else if (w_active) begin
            w_cur_note_nxt = io.pressed_key;
            w_dur_nxt      = {{(DUR_W-1){1'b0}}, 1'b1};
            w_state_nxt    = HOLD;
`ifdef RECORD_REST_EN
            // Leading silence (nothing stored yet) is never recorded.
            if (r_rest_cnt >= MIN_T && r_count != '0) begin
              w_we      = 1'b1;
              w_wr_note = 4'd0;
              w_wr_dur  = r_rest_cnt;
            end
`endif
          end else begin
`ifdef RECORD_REST_EN
            w_rest_nxt = w_rest_inc;
`endif
          end
        end
        HOLD: begin
          if (io.rec_stop) begin
            w_we        = w_commit_ok;
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else if (!w_active) begin
            w_we        = w_commit_ok;
            w_state_nxt = WAIT_KEY;
`ifdef RECORD_REST_EN
            w_rest_nxt  = {{(DUR_W-1){1'b0}}, 1'b1};
`endif
          end else if (io.pressed_key != r_cur_note) begin
            // Direct key change: close the old note and open the new one in the same cycle.
            w_we           = w_commit_ok;
            w_cur_note_nxt = io.pressed_key;
            w_dur_nxt      = {{(DUR_W-1){1'b0}}, 1'b1};
          end else begin
            w_dur_nxt = w_dur_inc;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    // A write that fills the buffer ends recording; a note opened this cycle is dropped.
    if (w_we) begin
      w_count_nxt = r_count + 1'b1;
      if (w_count_nxt == FULL_CNT) begin
        w_full_nxt  = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cur_note <= 4'd0;
      r_dur_cnt  <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_rec_done <= 1'b0;
`ifdef RECORD_REST_EN
      r_rest_cnt <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_cur_note <= w_cur_note_nxt;
      r_dur_cnt  <= w_dur_nxt;
      r_count    <= w_count_nxt;
      r_full     <= w_full_nxt;
      r_rec_done <= w_done_nxt;
`ifdef RECORD_REST_EN
      r_rest_cnt <= w_rest_nxt;
`endif
    end
  end

  // Storage is not reset; entries at or above note_count are masked on read.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_count[DEPTH_LOG2-1:0]] <= {w_wr_note, w_wr_dur};
    end
  end

  assign w_rd_hit       = ({1'b0, io.rd_index} < r_count);
  assign w_rd_ent       = r_mem[io.rd_index];
  assign io.rd_note     = w_rd_hit ? w_rd_ent[DUR_W+3:DUR_W] : 4'd0;
  assign io.rd_duration = w_rd_hit ? w_rd_ent[DUR_W-1:0]     : '0;
  assign io.note_count  = r_count;
  assign io.recording   = (r_state != IDLE);
  assign io.full        = r_full;
  assign io.rec_done    = r_rec_done;
endmodule

// File: tb/tb_note_recorder.sv
// tb_note_recorder: bench for note_recorder with a 4-entry buffer, 8-bit durations, MIN_TICKS=4.
// Expected entries come from a behavioural model and are compared as the DUT's note_count grows.
module tb_note_recorder;
  localparam int DL2 = 2;
  localparam int DW  = 8;
  localparam int MIN = 4;
  localparam int CAP = 1 << DL2;
`ifdef RECORD_REST_EN
  localparam bit REST_EN = 1'b1;
`else
  localparam bit REST_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]    note;
    logic [DW-1:0] dur;
  } ent_t;

  typedef struct {
    int key;
    int hold;
    int gap;
    int cnt;
    int cnt_r;
  } vec_t;

  logic clk;
  logic rst;
  note_recorder_if #(.DEPTH_LOG2(DL2), .DUR_W(DW)) bus ();

  note_recorder #(.DEPTH_LOG2(DL2), .DUR_W(DW), .MIN_TICKS(MIN)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ent_t exp_q[$];
  int   n_chk = 0, n_fail = 0;
  int   m_count = 0, exp_done = 0, got_done = 0, last_cnt = 0;
  bit   m_rec = 0, m_full = 0;
  int   p_note = 0, p_dur = 0, m_gap = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic int sat(input int v);
    return (v > (1 << DW) - 1) ? (1 << DW) - 1 : v;
  endfunction

  // One clock; sample at the falling edge and score any new entry.
  task automatic tick();
    ent_t e;
    @(posedge clk);
    @(negedge clk);
    if (bus.rec_done) got_done++;
    if (int'(bus.note_count) == last_cnt + 1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected_write: got count %0d, required %0d", bus.note_count, last_cnt);
      end else begin
        e = exp_q.pop_front();
        bus.rd_index = 2'(bus.note_count - 3'd1);
        #1;
        chk("sb_note", 32'(bus.rd_note), 32'(e.note));
        chk("sb_dur", 32'(bus.rd_duration), 32'(e.dur));
      end
    end
    last_cnt = int'(bus.note_count);
  endtask

  task automatic m_write(input int note, input int dur);
    ent_t e;
    if (!m_rec) return;
    e.note = 4'(note);
    e.dur  = DW'(dur);
    exp_q.push_back(e);
    m_count++;
    if (m_count == CAP) begin
      m_rec  = 0;
      m_full = 1;
      exp_done++;
    end
  endtask

  task automatic m_commit();
    if (m_rec && p_dur >= MIN) m_write(p_note, sat(p_dur));
    p_dur = 0;
  endtask

  task automatic press(input int k, input int n);
    if (m_rec) begin
      if (p_dur > 0) m_commit();
      else if (REST_EN && m_gap >= MIN && m_count > 0) m_write(0, sat(m_gap));
      m_gap = 0;
      if (m_rec) begin
        p_note = k;
        p_dur  = n;
      end
    end
    bus.pressed_key = 4'(k);
    bus.key_pressed = 1'b1;
    repeat (n) tick();
  endtask

  task automatic gap(input int g);
    m_commit();
    m_gap = g;
    bus.pressed_key = 4'd0;
    bus.key_pressed = 1'b0;
    repeat (g) tick();
  endtask

  // rec_stop with the key left as it is, then release.
  task automatic stop_held();
    if (m_rec) begin
      m_commit();
      if (m_rec) begin
        m_rec = 0;
        exp_done++;
      end
    end
    bus.rec_stop = 1'b1;
    tick();
    bus.rec_stop    = 1'b0;
    bus.pressed_key = 4'd0;
    bus.key_pressed = 1'b0;
    m_gap = 0;
    tick();
  endtask

  task automatic start(input bit with_stop);
    m_rec = 1; m_full = 0; m_count = 0; p_dur = 0; m_gap = 0;
    bus.rec_start   = 1'b1;
    bus.rec_stop    = with_stop;
    bus.pressed_key = 4'd0;
    bus.key_pressed = 1'b0;
    tick();
    bus.rec_start = 1'b0;
    bus.rec_stop  = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_count"}, 32'(bus.note_count), 32'(m_count));
    chk({tag, "_recording"}, 32'(bus.recording), 32'(m_rec));
    chk({tag, "_full"}, 32'(bus.full), 32'(m_full));
    chk({tag, "_done_pulses"}, 32'(got_done), 32'(exp_done));
    chk({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_read(input string tag, input int idx, input int note, input int dur);
    bus.rd_index = 2'(idx);
    #1;
    chk({tag, "_note"}, 32'(bus.rd_note), 32'(note));
    chk({tag, "_dur"}, 32'(bus.rd_duration), 32'(dur));
  endtask

  vec_t tbl[4];

  initial begin
    // key, hold, gap, count without rests, count with rests
    tbl[0] = '{5, 10, 3, 1, 1};
    tbl[1] = '{3,  2, 6, 1, 1};  // glitch, discarded
    tbl[2] = '{9,  4, 2, 2, 3};  // exactly MIN ticks; rest of 6 precedes it when enabled
    tbl[3] = '{6,  3, 2, 2, 3};  // one short of MIN, discarded

    rst = 1'b1;
    bus.rec_start = 1'b0; bus.rec_stop = 1'b0;
    bus.pressed_key = 4'd0; bus.key_pressed = 1'b0; bus.rd_index = '0;
    #12;
    chk("rst_count", 32'(bus.note_count), 32'd0);
    chk("rst_recording", 32'(bus.recording), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    chk("rst_done", 32'(bus.rec_done), 32'd0);
    chk_read("rst_rd", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven song with a glitch, a boundary-length note and a short note.
    start(1'b0);
    chk("start_recording", 32'(bus.recording), 32'd1);
    for (int i = 0; i < 4; i++) begin
      press(tbl[i].key, tbl[i].hold);
      gap(tbl[i].gap);
      chk($sformatf("tbl%0d_count", i), 32'(bus.note_count),
          32'(REST_EN ? tbl[i].cnt_r : tbl[i].cnt));
    end
    stop_held();
    chk_state("song");
    chk_read("song_first", 0, 5, 10);
    chk_read("song_oob", REST_EN ? 3 : 2, 0, 0);

    // Direct key change, stopped while the second key is still held.
    start(1'b0);
    press(2, 6);
    press(7, 5);
    stop_held();
    chk_state("change");
    chk("change_count_const", 32'(bus.note_count), 32'd2);
    chk_read("change_e1", 1, 7, 5);

    // Gap between two notes: stored as a rest only when the feature is built in.
    start(1'b0);
    press(1, 5);
    gap(8);
    press(4, 5);
    stop_held();
    chk_state("rest");
    chk("rest_count_const", 32'(bus.note_count), REST_EN ? 32'd3 : 32'd2);
    chk_read("rest_e1", 1, REST_EN ? 0 : 4, REST_EN ? 8 : 5);

    // Duration saturates at the field maximum.
    start(1'b0);
    press(8, 300);
    gap(2);
    stop_held();
    chk_state("sat");
    chk_read("sat_e0", 0, 8, 255);

    // Fill the buffer; a 5th press and a rec_stop in IDLE must both be ignored.
    start(1'b0);
    for (int i = 0; i < CAP; i++) begin
      press(i + 10, 5);
      gap(2);
    end
    chk_state("full");
    chk("full_flag_const", 32'(bus.full), 32'd1);
    press(15, 5);
    gap(2);
    stop_held();
    chk_state("full_after");
    chk("full_count_const", 32'(bus.note_count), 32'(CAP));

    // Restart mid-note with rec_start and rec_stop together: start wins, no done pulse.
    start(1'b0);
    chk("restart_full_clear", 32'(bus.full), 32'd0);
    press(5, 6);
    start(1'b1);
    chk("restart_recording", 32'(bus.recording), 32'd1);
    press(3, 5);
    gap(2);
    stop_held();
    chk_state("restart");
    chk_read("restart_e0", 0, 3, 5);

    // Asynchronous reset in the middle of a held note after two stored notes.
    start(1'b0);
    press(5, 5);
    gap(2);
    press(6, 5);
    gap(2);
    press(7, 3);
    chk("prerst_count", 32'(bus.note_count), 32'd2);
    #2;
    rst = 1'b1;
    m_rec = 0; m_full = 0; m_count = 0; p_dur = 0; m_gap = 0;
    #1;
    chk_state("midrst");
    chk_read("midrst_rd", 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    last_cnt = 0;
    bus.pressed_key = 4'd0;
    bus.key_pressed = 1'b0;
    tick();
    chk_state("postrst");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
